// File: rtl/sdpram_arb_pkg.sv
// sdpram_arb_pkg: shared client count, client id and grant types for the sdpram arbiter
package sdpram_arb_pkg;
  localparam int NUM_CLIENTS = 2;
  typedef logic client_id_t;
  typedef struct packed {
    logic       valid;
    client_id_t id;
  } grant_t;
endpackage

// File: rtl/sdpram_arbiter_if.sv
// sdpram_arbiter_if: client handshakes plus RAM port A/B signals owned by the arbiter
interface sdpram_arbiter_if
  import sdpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [NUM_CLIENTS-1:0]                 w_valid;
  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_CLIENTS-1:0]                 w_ready;
  logic [NUM_CLIENTS-1:0]                 r_valid;
  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [NUM_CLIENTS-1:0]                 r_ready;
  logic [NUM_CLIENTS-1:0]                 r_rvalid;
  logic [DATA_WIDTH-1:0]                  r_rdata;
  logic                                   wena;
  logic [ADDR_WIDTH-1:0]                  addra;
  logic [DATA_WIDTH-1:0]                  dina;
  logic                                   renb;
  logic [ADDR_WIDTH-1:0]                  addrb;
  logic [DATA_WIDTH-1:0]                  doutb;
  modport slave (
    input  w_valid, w_addr, w_data, r_valid, r_addr, doutb,
    output w_ready, r_ready, r_rvalid, r_rdata, wena, addra, dina, renb, addrb
  );
  modport master (
    output w_valid, w_addr, w_data, r_valid, r_addr, doutb,
    input  w_ready, r_ready, r_rvalid, r_rdata, wena, addra, dina, renb, addrb
  );
endinterface

// File: rtl/sdpram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; the pointer toggles on every taken grant
module rr_arb2
  import sdpram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   adv,
  output logic [NUM_CLIENTS-1:0] gnt,
  output client_id_t             id
);
  client_id_t ptr_q, ptr_d;
  always_comb begin
    id    = &req ? ptr_q : req[1];
    gnt   = {NUM_CLIENTS{|req}} & {id, ~id};
    ptr_d = adv ? ~ptr_q : ptr_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
endmodule

// File: rtl/sdpram_arbiter.sv
// sdpram_arbiter: round-robin write/read arbitration in front of a simple dual-port RAM.
// SDPRAM_ARB_RAW_STALL_EN delays a read that hits the address being written this cycle.
module sdpram_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input logic clk,
  input logic rst,
  sdpram_arbiter_if.slave bus
);
  logic [NUM_CLIENTS-1:0] w_gnt, r_gnt;
  client_id_t             w_id, r_id, rtag_q, rtag_d;
  grant_t                 wg, rg;
  logic                   w_take, r_take, stall, rpend_q, rpend_d;
  logic [ADDR_WIDTH-1:0]  w_addr_win, r_addr_win;
  logic [DATA_WIDTH-1:0]  w_data_win;
  rr_arb2 u_warb (.clk, .rst, .req(bus.w_valid), .adv(w_take), .gnt(w_gnt), .id(w_id));
  rr_arb2 u_rarb (.clk, .rst, .req(bus.r_valid), .adv(r_take), .gnt(r_gnt), .id(r_id));
  always_comb begin
    wg.valid   = rst && (|bus.w_valid);
    wg.id      = w_id;
    rg.valid   = rst && (|bus.r_valid);
    rg.id      = r_id;
    w_addr_win = bus.w_addr[wg.id];
    w_data_win = bus.w_data[wg.id];
    r_addr_win = bus.r_addr[rg.id];
`ifdef SDPRAM_ARB_RAW_STALL_EN
    stall      = wg.valid && (r_addr_win == w_addr_win);
`else
    stall      = 1'b0;
`endif
    w_take       = wg.valid;
    r_take       = rg.valid && !stall;
    bus.w_ready  = w_take ? w_gnt : '0;
    bus.r_ready  = r_take ? r_gnt : '0;
    bus.wena     = w_take;
    bus.addra    = w_addr_win;
    bus.dina     = w_data_win;
    bus.renb     = r_take;
    bus.addrb    = r_addr_win;
    rpend_d      = r_take;
    rtag_d       = rg.id;
    bus.r_rvalid = {rpend_q & rtag_q, rpend_q & ~rtag_q};
    bus.r_rdata  = bus.doutb;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rpend_q <= 1'b0;
      rtag_q  <= '0;
    end else begin
      rpend_q <= rpend_d;
      rtag_q  <= rtag_d;
    end
endmodule

// File: tb/tb_sdpram_arbiter.sv
// tb_sdpram_arbiter: directed and random checks of sdpram_arbiter against a shadow-memory model
module tb_sdpram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  sdpram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();
  sdpram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] ram [64];
  logic [7:0] shadow [64];
  always @(posedge clk) begin
    if (bus.renb) bus.doutb <= ram[bus.addrb];
    if (bus.wena) ram[bus.addra] <= bus.dina;
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  bit         m_wptr, m_rptr, m_pend, m_tag;
  logic [7:0] m_data;
  bit         e_wgo, e_rgo, e_wi, e_ri;
  logic [5:0] e_wa, e_ra;
  logic [7:0] e_wd;
  always begin
    @(negedge clk);
    e_wgo = rst && bus.w_valid != 2'b00;
    e_wi  = (bus.w_valid == 2'b11) ? m_wptr : !bus.w_valid[0];
    e_rgo = rst && bus.r_valid != 2'b00;
    e_ri  = (bus.r_valid == 2'b11) ? m_rptr : !bus.r_valid[0];
    e_wa  = bus.w_addr[e_wi];
    e_wd  = bus.w_data[e_wi];
    e_ra  = bus.r_addr[e_ri];
`ifdef SDPRAM_ARB_RAW_STALL_EN
    if (e_wgo && e_ra == e_wa) e_rgo = 1'b0;
`endif
    chk("m_w_ready", bus.w_ready, e_wgo ? (e_wi ? 2 : 1) : 0);
    chk("m_r_ready", bus.r_ready, e_rgo ? (e_ri ? 2 : 1) : 0);
    chk("m_wena", bus.wena, e_wgo);
    chk("m_renb", bus.renb, e_rgo);
    if (e_wgo) chk("m_addra", bus.addra, e_wa);
    if (e_wgo) chk("m_dina", bus.dina, e_wd);
    if (e_rgo) chk("m_addrb", bus.addrb, e_ra);
    chk("m_r_rvalid", bus.r_rvalid, (rst && m_pend) ? (m_tag ? 2 : 1) : 0);
    if (rst && m_pend) chk("m_r_rdata", bus.r_rdata, m_data);
    @(posedge clk);
    if (!rst) begin
      m_wptr = 0;
      m_rptr = 0;
      m_pend = 0;
    end else begin
      m_pend = e_rgo;
      m_tag  = e_ri;
      m_data = shadow[e_ra];
      if (e_wgo) shadow[e_wa] = e_wd;
      if (e_wgo) m_wptr = !m_wptr;
      if (e_rgo) m_rptr = !m_rptr;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic set_w(logic [1:0] v, logic [5:0] a0, logic [7:0] d0, logic [5:0] a1, logic [7:0] d1);
    bus.w_valid = v;
    bus.w_addr[0] = a0;
    bus.w_data[0] = d0;
    bus.w_addr[1] = a1;
    bus.w_data[1] = d1;
  endtask
  task automatic set_r(logic [1:0] v, logic [5:0] a0, logic [5:0] a1);
    bus.r_valid = v;
    bus.r_addr[0] = a0;
    bus.r_addr[1] = a1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    set_w(0, 0, 0, 0, 0);
    set_r(0, 0, 0);
    mid();
    chk("reset_r_rvalid", bus.r_rvalid, 0);
    chk("reset_wena", bus.wena, 0);
    chk("reset_renb", bus.renb, 0);
    tick();
    rst = 1'b1;
    // single writer, then a client-1 read of the same address
    set_w(2'b01, 6'h05, 8'hA5, 0, 0);
    mid();
    chk("single_w_ready", bus.w_ready, 2'b01);
    chk("single_wena", bus.wena, 1);
    tick();
    set_w(0, 0, 0, 0, 0);
    set_r(2'b10, 0, 6'h05);
    mid();
    chk("single_r_ready", bus.r_ready, 2'b10);
    tick();
    set_r(0, 0, 0);
    mid();
    chk("single_r_rvalid", bus.r_rvalid, 2'b10);
    chk("single_r_rdata", bus.r_rdata, 8'hA5);
    tick();
    // write contention alternates 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_w(2'b11, 6'h10, 8'h40 + 8'(i), 6'h20, 8'h80 + 8'(i));
      mid();
      chk("wcont_w_ready", bus.w_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
    end
    set_w(0, 0, 0, 0, 0);
    set_r(2'b01, 6'h10, 0);
    tick();
    set_r(0, 0, 0);
    mid();
    chk("wcont_last0", bus.r_rdata, 8'h42);
    tick();
    set_r(2'b10, 0, 6'h20);
    tick();
    set_r(0, 0, 0);
    mid();
    chk("wcont_last1", bus.r_rdata, 8'h83);
    tick();
    // read contention: responses follow grants by one cycle
    do_reset();
    set_r(2'b11, 6'h10, 6'h20);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) set_r(0, 0, 0);
      mid();
      if (i < 4) chk("rcont_r_ready", bus.r_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i > 0) chk("rcont_r_rvalid", bus.r_rvalid, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) chk("rcont_r_rdata", bus.r_rdata, (i % 2 == 0) ? 8'h83 : 8'h42);
      tick();
    end
    // same-cycle write/read collision on address 0x07
    set_w(2'b01, 6'h07, 8'h11, 0, 0);
    tick();
    set_w(2'b01, 6'h07, 8'h3C, 0, 0);
    set_r(2'b10, 0, 6'h07);
    mid();
`ifdef SDPRAM_ARB_RAW_STALL_EN
    chk("coll_stall_r_ready", bus.r_ready, 2'b00);
    tick();
    set_w(0, 0, 0, 0, 0);
    mid();
    chk("coll_retry_r_ready", bus.r_ready, 2'b10);
    tick();
    set_r(0, 0, 0);
    mid();
    chk("coll_r_rvalid", bus.r_rvalid, 2'b10);
    chk("coll_r_rdata", bus.r_rdata, 8'h3C);
`else
    chk("coll_r_ready", bus.r_ready, 2'b10);
    tick();
    set_w(0, 0, 0, 0, 0);
    set_r(0, 0, 0);
    mid();
    chk("coll_r_rvalid", bus.r_rvalid, 2'b10);
    chk("coll_r_rdata", bus.r_rdata, 8'h11);
`endif
    tick();
    // reset asserted the cycle after a read is accepted
    set_r(2'b01, 6'h05, 0);
    tick();
    set_r(0, 0, 0);
    rst = 1'b0;
    mid();
    chk("rstmid_r_rvalid", bus.r_rvalid, 2'b00);
    tick();
    tick();
    rst = 1'b1;
    set_w(2'b11, 6'h30, 8'h01, 6'h31, 8'h02);
    set_r(2'b11, 6'h32, 6'h33);
    mid();
    chk("rstmid_w_ptr0", bus.w_ready, 2'b01);
    chk("rstmid_r_ptr0", bus.r_ready, 2'b01);
    tick();
    // random soak checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      set_w(2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 8'($urandom),
            6'($urandom_range(0, 7)), 8'($urandom));
      set_r(2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      mid();
      chk("soak_one_w", 32'($countones(bus.w_ready) <= 1), 1);
      chk("soak_one_r", 32'($countones(bus.r_ready) <= 1), 1);
      tick();
    end
    set_w(0, 0, 0, 0, 0);
    set_r(0, 0, 0);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdpram_arbiter.md
# sdpram_arbiter

- Two-client arbiter/scheduler in front of `simple_dual_port_ram`.
- Write port: two write requesters share RAM port A through a valid/ready handshake with round-robin arbitration.
- Read port: two read requesters share RAM port B the same way; each accepted read returns data the following cycle, steered back to the requester that issued it.
- Sits between the client logic and the RAM's `sdpram_if` signals; owns every RAM control line.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 6, RAM address width (depth = 2**ADDR_WIDTH).

Ports (all arrays indexed by client 0/1):
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `w_valid`  in  [2]  write request per client.
- `w_addr`  in  [2][ADDR_WIDTH]  write address per client.
- `w_data`  in  [2][DATA_WIDTH]  write data per client.
- `w_ready`  out  [2]  write accepted this cycle.
- `r_valid`  in  [2]  read request per client.
- `r_addr`  in  [2][ADDR_WIDTH]  read address per client.
- `r_ready`  out  [2]  read accepted this cycle.
- `r_rvalid`  out  [2]  read data valid for client.
- `r_rdata`  out  DATA_WIDTH  read data, shared bus.
- `wena`, `addra`, `dina`  out  1/ADDR_WIDTH/DATA_WIDTH  RAM port A.
- `renb`, `addrb`  out  1/ADDR_WIDTH  RAM port B.
- `doutb`  in  DATA_WIDTH  RAM read data; registered, valid one cycle after `renb` is sampled.

## Operation
- A transfer occurs when `x_valid[k] && x_ready[k]` at a rising edge.
- Ready is combinational from valid and the priority pointer. At most one `w_ready` and one `r_ready` are high per cycle.
- **Write grant**
  - Only one valid: that client wins.
  - Both valid: the client pointed to by `wptr` wins.
  - `wena` = any write grant; `addra`/`dina` are muxed from the winner.
  - `wptr` flips to the other client after each grant; it holds when there is no grant.
- **Read grant**: same scheme with `rptr`.
  - `renb` = any read grant; `addrb` is muxed from the winner.
  - The winner id is registered into `rtag`, and `rpend` is set for one cycle.
- **Response**
  - `r_rvalid[rtag] = rpend`; the other `r_rvalid` bit is 0.
  - `r_rdata = doutb`, passed through with no extra register.
  - No backpressure on responses; clients must sink data the cycle it is valid.
- **Independence**: the two ports arbitrate fully independently, so one write and one read complete in the same cycle.
- **Same-cycle collision**: the RAM returns pre-write contents when `addra == addrb` with `wena && renb`. Handling is defined under Configuration.
- **Reset (`rst` low)**
  - Outputs: `wptr=0`, `rptr=0`, `rpend=0`, all `r_rvalid=0`. `wena=0` and `renb=0` whenever no valid is high.
  - Mid-operation: an in-flight read response is dropped (`r_rvalid` is forced low); a write in the same cycle is not committed.

## Timing
- Write latency:
  - Accepted at edge N; RAM updated at edge N.
  - A read issued at edge N+1 or later sees the new data.
- Read latency:
  - Accepted at edge N; `r_rvalid`/`r_rdata` are valid during cycle N+1 and sampled at edge N+1.
- Throughput: one write and one read per cycle, sustained.
- Fairness: under continuous contention, grants alternate 0,1,0,1 on each port.
- Combinational paths: valid → ready → RAM controls. No combinational path from `doutb` to any ready.

## Configuration
- Macro: `SDPRAM_ARB_RAW_STALL_EN`.
- **Defined**
  - When the read winner's address equals `addra` with `wena` high in the same cycle, all `r_ready` are held 0 and `renb=0`.
  - `rptr` does not advance.
  - The read is issued the next cycle, so it returns the newly written data.
- **Undefined**
  - No stall; the read is issued and returns the pre-write contents.

## Structure
- Package `sdpram_arb_pkg` holds:
  - `NUM_CLIENTS = 2`.
  - `typedef logic client_id_t`.
  - A `grant_t` packed struct with fields `valid` and `id`.
- Sub-module `rr_arb2`:
  - Inputs: request[2] and an advance enable.
  - Outputs: one-hot grant and the winner id.
  - Holds its own pointer with async active-low reset.
  - Instantiated twice (write and read).

## Test plan
- **Single writer**: client 0 writes addr 0x05 data 0xA5 → `w_ready[0]` high same cycle, `wena=1`. A client-1 read of 0x05 one cycle later → `r_rvalid[1]` with 0xA5 the following cycle.
- **Write contention**: both clients hold `w_valid` 4 cycles (addrs 0x10/0x20) → grants 0,1,0,1. Memory holds the last data from each client.
- **Read contention**: both read different preloaded addrs for 4 cycles → `r_rvalid` alternates 0,1,0,1 one cycle behind, with the correct data each time.
- **Collision**: write 0x3C→addr 0x07 in the same cycle as a read of 0x07 (old value 0x11).
  - Macro set: `r_ready=0` that cycle; 0x3C is returned one cycle later.
  - Macro clear: 0x11 is returned.
- **Reset mid-read**: drop `rst` in the cycle after a read is accepted → `r_rvalid` stays 0. After release both pointers favour client 0.
- **Random soak**: 10000 random valid/addr/data cycles compared against a scoreboard shadow memory → zero mismatches, no double grants.
